// File: rtl/sync_pkg.sv
// Shared definitions for the sync divider/multiplier pair: FSM states,
// select width and the select-to-factor mapping used by both displays.
package sync_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    // Factor shown on the 7-segment display: 1, 2, 4 or 8.
    function automatic logic [3:0] factor_from_sel(input logic [SEL_W-1:0] sel);
        return 4'(4'd1 << sel);
    endfunction

endpackage

// File: rtl/period_meter.sv
// Measures cycles between consecutive sync pulses with a saturating counter;
// flags a usable period on each sync and a timeout while saturated.
module period_meter #(
    parameter int PERIOD_W = 24
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                sync_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                timeout
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic [PERIOD_W-1:0] cnt;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (sync_in) begin
            cnt <= PERIOD_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    // A sync landing exactly on saturation is still the longest legal period.
    assign period       = cnt;
    assign period_valid = sync_in;
    assign timeout      = (cnt == CNT_MAX) && !sync_in;

endmodule

// File: rtl/syncmultiplier.sv
// Sync rate multiplier: passes each sync through and fills the following
// period with evenly spaced interpolated pulses (factor 1, 2, 4 or 8).
module syncmultiplier
    import sync_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       sync_in,
    input  logic       pb_mulby,
    output logic       sync_out,
    output logic [3:0] mulby,
    output logic       locked
);

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [PERIOD_W-1:0] interval;
    logic [PERIOD_W-1:0] down_cnt;
    logic [2:0]          pulses_left;

    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                timeout;

    logic [PERIOD_W-1:0] new_interval;
    logic [3:0]          new_factor;
    logic                start_run;

    period_meter #(.PERIOD_W(PERIOD_W)) u_period_meter (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .sync_in      (sync_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    // A coincident press is seen here with the old sel, so that sync keeps the old factor.
    assign new_interval = period >> sel;
    assign new_factor   = factor_from_sel(sel);
    assign start_run    = (sel != '0) && (new_interval >= PERIOD_W'(2));
    assign mulby        = factor_from_sel(sel);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel <= '0;
        end else if (pb_mulby) begin
            sel <= sel + SEL_W'(1);
        end
    end

    // NOTE: every register, datapath included, is reset so a mid-sequence reset restarts from power-up state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            locked      <= 1'b0;
            sync_out    <= 1'b0;
            interval    <= '0;
            down_cnt    <= '0;
            pulses_left <= '0;
        end else begin
            sync_out <= 1'b0;
            if (period_valid) begin
                // Sync wins over any expiry in the same cycle: one pulse only.
                sync_out <= 1'b1;
                if (!locked) begin
                    locked <= 1'b1;
                    state  <= IDLE;
                end else if (start_run) begin
                    state       <= RUN;
                    interval    <= new_interval;
                    down_cnt    <= new_interval;
                    pulses_left <= 3'(new_factor - 4'd1);
                end else begin
                    state <= WAIT;
                end
            end else if (timeout) begin
                locked <= 1'b0;
                state  <= IDLE;
            end else if (state == RUN) begin
                if (down_cnt == PERIOD_W'(1)) begin
                    sync_out    <= 1'b1;
                    down_cnt    <= interval;
                    pulses_left <= pulses_left - 3'd1;
                    if (pulses_left == 3'd1) begin
                        state <= WAIT;
                    end
                end else begin
                    down_cnt <= down_cnt - PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_syncmultiplier.sv
// Self-checking bench: an event-level model schedules expected pulse times
// from sync times and the press count, compared against the DUT every cycle.
module tb_syncmultiplier;

    localparam int PERIOD_W = 8;
    localparam int CNT_MAX  = (1 << PERIOD_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync_in;
    logic       pb_mulby;
    logic       sync_out;
    logic [3:0] mulby;
    logic       locked;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int   pending[$];
    bit   m_locked;
    int   m_last;
    int   m_sel;
    bit   check_spacing = 1'b0;
    logic prev_out      = 1'b0;

    syncmultiplier #(.PERIOD_W(PERIOD_W)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .sync_in  (sync_in),
        .pb_mulby (pb_mulby),
        .sync_out (sync_out),
        .mulby    (mulby),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        m_locked = 1'b0;
        m_last   = 0;
        m_sel    = 0;
        cyc      = 0;
        prev_out = 1'b0;
    endtask

    // Applies the rules for one clock edge closing cycle cyc.
    task automatic model_edge(input bit s, input bit p);
        int per, fac, ival;
        if (s) begin
            while (pending.size() > 0 && pending[$] >= cyc + 1) void'(pending.pop_back());
            pending.push_back(cyc + 1);
            if (m_locked) begin
                per  = cyc - m_last;
                fac  = 1 << m_sel;
                ival = per / fac;
                if (fac > 1 && ival >= 2)
                    for (int k = 1; k < fac; k++) pending.push_back(cyc + 1 + k * ival);
            end else begin
                m_locked = 1'b1;
            end
            m_last = cyc;
        end else if (m_locked && (cyc - m_last) >= CNT_MAX) begin
            m_locked = 1'b0;
            pending.delete();
        end
        if (p) m_sel = (m_sel + 1) % 4;
    endtask

    task automatic step(input bit s, input bit p);
        bit exp_out;
        sync_in  = s;
        pb_mulby = p;
        @(posedge clk);
        model_edge(s, p);
        cyc++;
        @(negedge clk);
        exp_out = 1'b0;
        if (pending.size() > 0 && pending[0] == cyc) begin
            exp_out = 1'b1;
            void'(pending.pop_front());
        end
        check("sync_out", sync_out, exp_out);
        check("locked", locked, m_locked);
        check("mulby", mulby, 1 << m_sel);
        if (check_spacing) check("spacing", prev_out & sync_out, 0);
        prev_out = sync_out;
        sync_in  = 1'b0;
        pb_mulby = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic sync_after(input int gap);
        idle(gap - 1);
        step(1'b1, 1'b0);
    endtask

    task automatic press(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        // Inputs active during reset must be ignored.
        rst_n    = 1'b0;
        sync_in  = 1'b1;
        pb_mulby = 1'b1;
        #23;
        @(negedge clk);
        sync_in  = 1'b0;
        pb_mulby = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        check("rst_sync_out", sync_out, 0);
        check("rst_locked", locked, 0);
        check("rst_mulby", mulby, 1);

        // M=1, period 100.
        idle(3);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) sync_after(100);

        // M=2 then M=8, period 100.
        press(1);
        sync_after(99);
        for (int i = 0; i < 2; i++) sync_after(100);
        press(2);
        sync_after(98);
        for (int i = 0; i < 2; i++) sync_after(100);

        // M=4, early sync at 60 drops the rest and restarts with I=15.
        press(3);
        sync_after(97);
        sync_after(100);
        sync_after(60);
        sync_after(100);

        // Short periods: I=0 at M=8, I=1 at M=4.
        press(1);
        sync_after(6);
        check_spacing = 1'b1;
        for (int i = 0; i < 5; i++) sync_after(7);
        press(3);
        sync_after(4);
        for (int i = 0; i < 5; i++) sync_after(7);
        check_spacing = 1'b0;

        // Timeout, then relock with pass-through only, then a full sequence.
        idle(300);
        step(1'b1, 1'b0);
        sync_after(100);
        sync_after(100);

        // Press coincident with sync at M=2.
        press(3);
        sync_after(97);
        sync_after(100);
        idle(99);
        step(1'b1, 1'b1);
        sync_after(100);
        sync_after(100);

        // Random periods (some beyond timeout) and random presses.
        for (int n = 0; n < 25; n++) begin
            int gap;
            gap = $urandom_range(300, 2);
            for (int i = 0; i < gap - 1; i++) step(1'b0, $urandom_range(19, 0) == 0);
            step(1'b1, $urandom_range(3, 0) == 0);
        end
        idle(120);

        // Asynchronous reset while a pulse is high mid-sequence.
        press(1);
        sync_after(50);
        sync_after(80);
        rst_n = 1'b0;
        #1;
        check("async_rst_sync_out", sync_out, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_mulby", mulby, 1);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(5);
        step(1'b1, 1'b0);
        press(1);
        sync_after(39);
        sync_after(40);
        idle(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syncmultiplier.md
# syncmultiplier

Multiplies the rate of an incoming one-cycle sync pulse train by a user-selectable factor of 1, 2, 4 or 8. It measures the period between consecutive `sync_in` pulses and emits evenly spaced one-cycle pulses within the following period. It is the counterpart of the sync divider and sits on the same sync path: it produces a faster tick, for example sub-beat ticks, from a slow external or divided sync. Push-button and display ports match the divider's so both blocks share the same front-panel handling.

## Interface
- `PERIOD_W`, 24: width of the period counter; the longest measurable period is 2^PERIOD_W-1 cycles.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `sync_in` in 1: input sync; high exactly one cycle per event.
- `pb_mulby` in 1: debounced one-cycle press; cycles the factor 1→2→4→8→1.
- `sync_out` out 1: multiplied sync; each pulse is high exactly one cycle.
- `mulby` out 4: currently selected factor (1, 2, 4 or 8) for the 7-segment display.
- `locked` out 1: high while a valid measured period is held.

## Operation
- Internal 2-bit `sel` (0..3); factor M = 1<<sel. `mulby` = M, combinational from `sel`.
- Period counter `cnt`:
  - Loaded with 1 in a `sync_in` cycle.
  - Otherwise increments, saturating at all-ones.
- On a `sync_in` with `locked`=1:
  - P = `cnt`, the cycles since the previous `sync_in`.
  - I = P >> `sel_eff`, where `sel_eff` = `sel` as of that cycle, latched into M_run.
  - The interpolation sequence for the new period starts.
- States:
  - IDLE (no valid period): `sync_in` → pass-through pulse, `locked`←1, stay IDLE with measurement started. The first sync after reset or timeout is therefore pass-through only.
  - RUN: a down-counter reloads with I after each emitted pulse; on expiry it emits an interpolated pulse. After M_run-1 interpolated pulses it goes to WAIT.
  - WAIT: all pulses emitted; waiting for `sync_in`.
  - Any `sync_in` in RUN or WAIT: emit the pass-through pulse, drop remaining interpolated pulses, and restart RUN with the new P and I. This realigns phase and gives no catch-up burst.
- Entry into RUN from IDLE/WAIT requires M_run>1 and I≥2. Otherwise go to WAIT: pass-through only, no consecutive-cycle pulses.
- Timeout: when `cnt` saturates, `locked`←0, state←IDLE, any sequence in progress is aborted.
- `pb_mulby`:
  - `sel`←`sel`+1, wrapping 3→0.
  - Affects only sequences started by later `sync_in` pulses.
  - If coincident with `sync_in`, the sync uses the old `sel`.
- Truncation remainder (P mod M) is absorbed in the last sub-interval before the next sync.

## Timing
- Reset values:
  - `sync_out`=0, `locked`=0, `sel`=0 (so `mulby`=1), state IDLE, `cnt`=0.
  - Any `pb_mulby`/`sync_in` during reset is ignored.
- `sync_out` is registered. The pass-through pulse appears 1 cycle after `sync_in` (cycle t+1).
- Interpolated pulse k (k=1..M_run-1) appears at t+1+k·I, unless the next `sync_in` arrives first.
- Pulse spacing is never below 2 cycles. There are never two `sync_out` pulses in one cycle: a `sync_in` coincident with a counter expiry yields only the pass-through pulse.
- `locked` rises at the cycle after the first `sync_in` (t+1). It falls the cycle after `cnt` saturates.
- Reset asserted mid-sequence: all outputs clear immediately (asynchronous). After release, behaviour is as from power-up.

## Structure
- Shared package `sync_pkg`:
  - state enum {IDLE, RUN, WAIT};
  - `SEL_W`=2;
  - the factor-from-select function, shared with the divider's `divby` display logic.
- Sub-module `period_meter`:
  - holds `cnt` with saturation and the load on `sync_in`;
  - outputs P, `period_valid` strobe and `timeout` strobe.
- Top level holds the pulse FSM, the interval down-counter, the pulse counter and `sel`.

## Test plan
- Reset then `sync_in` every 100 cycles, M=1:
  - `sync_out` only at each sync+1;
  - `mulby`=1;
  - `locked`=1 from the first sync+1.
- One `pb_mulby` press (M=2), then two more presses (M=8), sync every 100 cycles:
  - M=2, period 100: pulses at t+1 and t+51.
  - M=8, period 100: I=12, pulses at t+1, t+13, …, t+85.
- Locked at P=100, M=4, next `sync_in` arrives 60 cycles after t:
  - pulses at t+1, t+26, t+51, then t+61 (pass-through);
  - the t+76 pulse is dropped;
  - the new sequence uses I=15.
- P=7, M=8 (I=0), and P=7, M=4 (I=1): pass-through pulses only; never consecutive-cycle pulses.
- `PERIOD_W`=8, stop `sync_in` after lock:
  - `locked` falls 1 cycle after `cnt` reaches 255;
  - the next `sync_in` gives pass-through only.
- `pb_mulby` coincident with `sync_in` at M=2:
  - the current period uses M=2;
  - the following sync's sequence uses M=4;
  - `mulby` reads 4 from the next cycle.
